// File: rtl/i2c_pwm_pkg.sv
// Shared types and constants for the I2C-controlled PWM LED block.
// Register offsets above the duty bank are relative to the channel count.
package i2c_pwm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Duty registers start at REG_DUTY0; enable mask sits at CH_CNT, ID at CH_CNT+1.
  localparam int REG_DUTY0  = 0;
  localparam int REG_EN_OFS = 0;
  localparam int REG_ID_OFS = 1;

endpackage

// File: rtl/i2c_pwm_ctrl_pwm.sv
// Shared free-running PWM counter with per-channel shadow duty registers.
// Shadows reload only at the counter wrap, so a period is never cut short.
module pwm_channel_bank
  import i2c_pwm_pkg::*;
#(
  parameter int CH_CNT = 4,
  parameter int PWM_W  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CH_CNT-1:0][PWM_W-1:0]   i_duty,
  input  logic [CH_CNT-1:0]              i_en,
  output logic [CH_CNT-1:0]              o_pwm
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PWM_W-1:0]              r_cnt;
  logic [CH_CNT-1:0][PWM_W-1:0]  r_shadow;
  logic [CH_CNT-1:0]             r_pwm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_pwm    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_MAX) begin
        r_shadow <= i_duty;
      end
      for (int i = 0; i < CH_CNT; i++) begin
        r_pwm[i] <= i_en[i] && (r_cnt < r_shadow[i]);
      end
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/i2c_pwm_ctrl.sv
// I2C target with an addressed register file (duty per channel, enable mask, ID)
// driving a bank of PWM LED outputs. No clock stretching; SDA is open-drain.
module i2c_pwm_ctrl
  import i2c_pwm_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'h4A,
  parameter int         CH_CNT  = 4,
  parameter int         PWM_W   = 8,
  parameter logic [7:0] ID_VAL  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  output logic              scl_o,
  input  logic              sda_i,
  output logic              sda_o,
  output logic [CH_CNT-1:0] pwm_o,
  output logic              busy_o
);

  localparam logic [3:0] REG_EN  = 4'(CH_CNT + REG_EN_OFS);
  localparam logic [3:0] REG_ID  = 4'(CH_CNT + REG_ID_OFS);
  localparam logic [7:0] PTR_MAX = 8'(CH_CNT + REG_ID_OFS);

  logic [SYNC_STAGES-1:0] r_sclSync;
  logic [SYNC_STAGES-1:0] r_sdaSync;
  logic                   r_sclPrev;
  logic                   r_sdaPrev;

  logic w_scl;
  logic w_sda;
  logic w_sclRise;
  logic w_sclFall;
  logic w_start;
  logic w_stop;

  logic [CH_CNT-1:0][PWM_W-1:0] r_duty;
  logic [CH_CNT-1:0]            r_en;

  state_t     r_state;
  logic [3:0] r_bitCnt;
  logic [3:0] r_ptr;
  logic [7:0] r_shift;
  logic [6:0] r_tx;
  logic       r_rw;
  logic       r_masterAck;
  logic       r_sda;
  logic       r_busy;

  logic [7:0] w_rxByte;
  logic [7:0] w_rdByte;
  logic [3:0] w_ptrInc;
  logic       w_wrEn;

  // Synchronisers reset to the idle bus level so leaving reset creates no false edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], scl_i};
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], sda_i};
      r_sclPrev <= r_sclSync[SYNC_STAGES-1];
      r_sdaPrev <= r_sdaSync[SYNC_STAGES-1];
    end
  end

  assign w_scl     = r_sclSync[SYNC_STAGES-1];
  assign w_sda     = r_sdaSync[SYNC_STAGES-1];
  assign w_sclRise = w_scl & ~r_sclPrev;
  assign w_sclFall = ~w_scl & r_sclPrev;
  assign w_start   = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
  assign w_stop    = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;

  assign w_rxByte = {r_shift[6:0], w_sda};
  assign w_ptrInc = (r_ptr == REG_ID) ? 4'd0 : r_ptr + 4'd1;
  assign w_wrEn   = (r_state == WDATA) && w_sclRise && (r_bitCnt == 4'd7);

  always_comb begin
    w_rdByte = 8'h00;
    for (int i = 0; i < CH_CNT; i++) begin
      if (r_ptr == 4'(REG_DUTY0 + i)) begin
        w_rdByte = 8'(r_duty[i]);
      end
    end
    if (r_ptr == REG_EN) begin
      w_rdByte = 8'(r_en);
    end
    if (r_ptr == REG_ID) begin
      w_rdByte = ID_VAL;
    end
  end

  // Writes land on the 8th data bit's SCL rise; writes to the ID offset fall through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty <= '0;
      r_en   <= '1;
    end else if (w_wrEn) begin
      for (int i = 0; i < CH_CNT; i++) begin
        if (r_ptr == 4'(REG_DUTY0 + i)) begin
          r_duty[i] <= w_rxByte[PWM_W-1:0];
        end
      end
      if (r_ptr == REG_EN) begin
        r_en <= w_rxByte[CH_CNT-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitCnt    <= 4'd0;
      r_ptr       <= 4'd0;
      r_shift     <= 8'h00;
      r_tx        <= 7'h00;
      r_rw        <= 1'b0;
      r_masterAck <= 1'b0;
      r_sda       <= 1'b1;
      r_busy      <= 1'b0;
    end else if (w_stop) begin
      r_state  <= IDLE;
      r_bitCnt <= 4'd0;
      r_sda    <= 1'b1;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      r_state  <= ADDR;
      r_bitCnt <= 4'd0;
      r_sda    <= 1'b1;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_sclRise) begin
            r_shift  <= w_rxByte;
            r_bitCnt <= r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            r_bitCnt <= 4'd0;
            if (r_shift[7:1] == ADDRESS) begin
              r_state <= ADDR_ACK;
              r_sda   <= 1'b0;
              r_busy  <= 1'b1;
              r_rw    <= r_shift[0];
            end else begin
              r_state <= IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (w_sclFall) begin
            if (r_rw) begin
              r_state <= RDATA;
              r_tx    <= w_rdByte[6:0];
              r_sda   <= w_rdByte[7];
            end else begin
              r_state <= REG;
              r_sda   <= 1'b1;
            end
          end
        end
        REG: begin
          if (w_sclRise) begin
            r_shift  <= w_rxByte;
            r_bitCnt <= r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            r_bitCnt <= 4'd0;
            if (r_shift <= PTR_MAX) begin
              r_ptr   <= r_shift[3:0];
              r_sda   <= 1'b0;
              r_state <= REG_ACK;
            end else begin
              r_state <= IGNORE;
            end
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (w_sclFall) begin
            r_sda   <= 1'b1;
            r_state <= WDATA;
          end
        end
        WDATA: begin
          if (w_sclRise) begin
            r_shift  <= w_rxByte;
            r_bitCnt <= r_bitCnt + 4'd1;
            if (r_bitCnt == 4'd7) begin
              r_ptr <= w_ptrInc;
            end
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            r_bitCnt <= 4'd0;
            r_sda    <= 1'b0;
            r_state  <= WDATA_ACK;
          end
        end
        // MSB was driven on entry; each following SCL fall presents the next bit.
        RDATA: begin
          if (w_sclRise) begin
            r_bitCnt <= r_bitCnt + 4'd1;
          end else if (w_sclFall) begin
            if (r_bitCnt == 4'd8) begin
              r_bitCnt <= 4'd0;
              r_sda    <= 1'b1;
              r_state  <= RDATA_ACK;
            end else begin
              r_sda <= r_tx[6];
              r_tx  <= {r_tx[5:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (w_sclRise) begin
            r_masterAck <= ~w_sda;
            if (!w_sda) begin
              r_ptr <= w_ptrInc;
            end
          end else if (w_sclFall) begin
            if (r_masterAck) begin
              r_state <= RDATA;
              r_tx    <= w_rdByte[6:0];
              r_sda   <= w_rdByte[7];
            end else begin
              r_state <= IGNORE;
            end
          end
        end
        IDLE, IGNORE: begin
        end
        default: begin
          r_state <= IDLE;
          r_sda   <= 1'b1;
        end
      endcase
    end
  end

  pwm_channel_bank #(
    .CH_CNT(CH_CNT),
    .PWM_W (PWM_W)
  ) u_pwmBank (
    .clk   (clk),
    .reset (reset),
    .i_duty(r_duty),
    .i_en  (r_en),
    .o_pwm (pwm_o)
  );

  assign scl_o  = 1'b1;
  assign sda_o  = r_sda;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_i2c_pwm_ctrl.sv
// Directed bench for i2c_pwm_ctrl: a bit-banged I2C master on a wired-AND bus,
// a table of write/readback vectors, and hand sequences for PWM, abort and reset.
module tb_i2c_pwm_ctrl;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mScl = 1'b1;
  logic       mSda = 1'b1;
  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic [3:0] pwm_o;
  logic       busy_o;

  int total = 0;
  int bad = 0;
  int sdaLowCnt = 0;
  int hiCnt [4];

  typedef struct {
    logic [7:0] addrByte;
    logic [7:0] ptr;
    logic [7:0] wdata;
    logic       expAddrAck;
    logic       expPtrAck;
    logic       expDataAck;
    logic [7:0] rbPtr;
    logic [7:0] expRead;
  } vec_t;

  vec_t vecs [11];

  assign scl_i = mScl & scl_o;
  assign sda_i = mSda & sda_o;

  i2c_pwm_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .scl_i (scl_i),
    .scl_o (scl_o),
    .sda_i (sda_i),
    .sda_o (sda_o),
    .pwm_o (pwm_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sda_o === 1'b0) sdaLowCnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2cStart();
    mSda = 1'b1; waitClk(Q);
    mScl = 1'b1; waitClk(Q);
    mSda = 1'b0; waitClk(Q);
    mScl = 1'b0; waitClk(Q);
  endtask

  task automatic i2cStop();
    mSda = 1'b0; waitClk(Q);
    mScl = 1'b1; waitClk(Q);
    mSda = 1'b1; waitClk(Q);
  endtask

  task automatic writeBit(input logic b);
    mSda = b;    waitClk(Q);
    mScl = 1'b1; waitClk(2 * Q);
    mScl = 1'b0; waitClk(Q);
  endtask

  task automatic readBit(output logic b);
    mSda = 1'b1; waitClk(Q);
    mScl = 1'b1; waitClk(Q);
    b = sda_i;   waitClk(Q);
    mScl = 1'b0; waitClk(Q);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) writeBit(d[i]);
    readBit(b);
    ack = ~b;
  endtask

  task automatic readByte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) readBit(d[i]);
    writeBit(~ack);
  endtask

  task automatic readReg(input logic [7:0] ptr, output logic [7:0] d, output logic ok);
    logic a0, a1, a2;
    i2cStart();
    writeByte(8'h94, a0);
    writeByte(ptr, a1);
    i2cStart();
    writeByte(8'h95, a2);
    readByte(d, 1'b0);
    i2cStop();
    ok = a0 & a1 & a2;
  endtask

  task automatic countPwm();
    for (int c = 0; c < 4; c++) hiCnt[c] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (pwm_o[c]) hiCnt[c]++;
    end
  endtask

  // One vector: a single-byte write transaction, then a readback through a repeated START.
  task automatic applyStimulus(input vec_t v, input int idx);
    int         lowBefore;
    logic       a0, a1, a2, ok;
    logic [7:0] d;
    lowBefore = sdaLowCnt;
    i2cStart();
    writeByte(v.addrByte, a0);
    writeByte(v.ptr, a1);
    writeByte(v.wdata, a2);
    checkOutput($sformatf("v%0d busyInTxn", idx), 32'(busy_o), 32'(v.expAddrAck));
    i2cStop();
    checkOutput($sformatf("v%0d addrAck", idx), 32'(a0), 32'(v.expAddrAck));
    checkOutput($sformatf("v%0d ptrAck", idx), 32'(a1), 32'(v.expPtrAck));
    checkOutput($sformatf("v%0d dataAck", idx), 32'(a2), 32'(v.expDataAck));
    checkOutput($sformatf("v%0d sdaDriven", idx), 32'(sdaLowCnt != lowBefore), 32'(v.expAddrAck));
    checkOutput($sformatf("v%0d busyAfterStop", idx), 32'(busy_o), 32'd0);
    readReg(v.rbPtr, d, ok);
    checkOutput($sformatf("v%0d rbAck", idx), 32'(ok), 32'd1);
    checkOutput($sformatf("v%0d rbData", idx), 32'(d), 32'(v.expRead));
  endtask

  initial begin
    logic       a0, a1, a2, a3, ok;
    logic [7:0] d;
    logic [7:0] expRd [6];
    int         n;

    vecs[0]  = '{8'h94, 8'h00, 8'h40, 1'b1, 1'b1, 1'b1, 8'h00, 8'h40};
    vecs[1]  = '{8'h94, 8'h01, 8'h80, 1'b1, 1'b1, 1'b1, 8'h01, 8'h80};
    vecs[2]  = '{8'h96, 8'h02, 8'h33, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00};
    vecs[3]  = '{8'h94, 8'h07, 8'h55, 1'b1, 1'b0, 1'b0, 8'h03, 8'h00};
    vecs[4]  = '{8'h94, 8'h05, 8'h12, 1'b1, 1'b1, 1'b1, 8'h05, 8'hA5};
    vecs[5]  = '{8'h94, 8'h04, 8'hFE, 1'b1, 1'b1, 1'b1, 8'h04, 8'h0E};
    vecs[6]  = '{8'h94, 8'h04, 8'h0F, 1'b1, 1'b1, 1'b1, 8'h04, 8'h0F};
    vecs[7]  = '{8'h94, 8'h06, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40};
    vecs[8]  = '{8'h94, 8'h03, 8'hC3, 1'b1, 1'b1, 1'b1, 8'h03, 8'hC3};
    vecs[9]  = '{8'h94, 8'h02, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h02, 8'h5A};
    vecs[10] = '{8'h14, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40};

    expRd[0] = 8'h40; expRd[1] = 8'h80; expRd[2] = 8'h00;
    expRd[3] = 8'h00; expRd[4] = 8'h0F; expRd[5] = 8'hA5;

    reset = 1'b1;
    waitClk(3);
    checkOutput("reset sda_o", 32'(sda_o), 32'd1);
    checkOutput("reset scl_o", 32'(scl_o), 32'd1);
    checkOutput("reset pwm_o", 32'(pwm_o), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    reset = 1'b0;
    waitClk(4);

    // Multi-byte write with auto-increment, then measure the resulting duty.
    i2cStart();
    writeByte(8'h94, a0);
    writeByte(8'h00, a1);
    writeByte(8'h40, a2);
    writeByte(8'h80, a3);
    i2cStop();
    checkOutput("wr addrAck", 32'(a0), 32'd1);
    checkOutput("wr ptrAck", 32'(a1), 32'd1);
    checkOutput("wr data0Ack", 32'(a2), 32'd1);
    checkOutput("wr data1Ack", 32'(a3), 32'd1);
    waitClk(600);
    countPwm();
    checkOutput("pwm0 highCount", 32'(hiCnt[0]), 32'd64);
    checkOutput("pwm1 highCount", 32'(hiCnt[1]), 32'd128);
    checkOutput("pwm2 highCount", 32'(hiCnt[2]), 32'd0);

    // Burst read of the whole map across a repeated START.
    i2cStart();
    writeByte(8'h94, a0);
    writeByte(8'h00, a1);
    i2cStart();
    writeByte(8'h95, a2);
    checkOutput("rd addrWAck", 32'(a0), 32'd1);
    checkOutput("rd ptrAck", 32'(a1), 32'd1);
    checkOutput("rd addrRAck", 32'(a2), 32'd1);
    for (int i = 0; i < 6; i++) begin
      readByte(d, i < 5);
      checkOutput($sformatf("rd byte%0d", i), 32'(d), 32'(expRd[i]));
    end
    i2cStop();

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // STOP after four data bits must leave duty0 untouched and the bus idle.
    i2cStart();
    writeByte(8'h94, a0);
    writeByte(8'h00, a1);
    for (int i = 0; i < 4; i++) writeBit(1'b1);
    i2cStop();
    checkOutput("abort addrAck", 32'(a0), 32'd1);
    checkOutput("abort ptrAck", 32'(a1), 32'd1);
    checkOutput("abort busy", 32'(busy_o), 32'd0);
    checkOutput("abort sda_o", 32'(sda_o), 32'd1);
    readReg(8'h00, d, ok);
    checkOutput("abort rbAck", 32'(ok), 32'd1);
    checkOutput("abort duty0", 32'(d), 32'h40);

    // Channel 0 at full duty but masked off; the others keep running.
    i2cStart();
    writeByte(8'h94, a0);
    writeByte(8'h00, a1);
    writeByte(8'hFF, a2);
    i2cStop();
    i2cStart();
    writeByte(8'h94, a0);
    writeByte(8'h04, a1);
    writeByte(8'h0E, a3);
    i2cStop();
    checkOutput("mask duty0Ack", 32'(a2), 32'd1);
    checkOutput("mask maskAck", 32'(a3), 32'd1);
    waitClk(600);
    countPwm();
    checkOutput("mask pwm0", 32'(hiCnt[0]), 32'd0);
    checkOutput("mask pwm1", 32'(hiCnt[1]), 32'd128);
    checkOutput("mask pwm2", 32'(hiCnt[2]), 32'h5A);
    checkOutput("mask pwm3", 32'(hiCnt[3]), 32'hC3);

    // Reset while the target is holding the address ACK.
    i2cStart();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h94;
      writeBit(d[i]);
    end
    mSda = 1'b1;
    waitClk(Q);
    mScl = 1'b1;
    n = 0;
    while (sda_o !== 1'b0 && n < 50) begin
      waitClk(1);
      n++;
    end
    checkOutput("rst ackDriven", 32'(sda_o), 32'd0);
    checkOutput("rst busyBefore", 32'(busy_o), 32'd1);
    reset = 1'b1;
    waitClk(1);
    checkOutput("rst sdaReleased", 32'(sda_o), 32'd1);
    checkOutput("rst busyCleared", 32'(busy_o), 32'd0);
    checkOutput("rst pwmCleared", 32'(pwm_o), 32'd0);
    reset = 1'b0;
    waitClk(4);
    mScl = 1'b0;
    waitClk(Q);
    i2cStop();
    readReg(8'h00, d, ok);
    checkOutput("rst rbAck0", 32'(ok), 32'd1);
    checkOutput("rst duty0", 32'(d), 32'h00);
    readReg(8'h01, d, ok);
    checkOutput("rst duty1", 32'(d), 32'h00);
    readReg(8'h04, d, ok);
    checkOutput("rst mask", 32'(d), 32'h0F);
    checkOutput("rst rbAck4", 32'(ok), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
